// File: rtl/sipo_rx_ctrl.sv
// Sequencer for a serial-in/parallel-out shift register: it clears the SIPO,
// gates its shifting, counts WIDTH bits and hands the word over on valid/ready.
module sipo_rx_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  output logic             sipo_shift_en,
  output logic             sipo_clr,
  input  logic [WIDTH-1:0] sipo_q,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

  state_t        state, state_next;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic          shift_en, clr;
  logic          capture, accept, load, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_en     = 1'b0;
    clr          = 1'b0;
    case (state)
      IDLE: begin
        clr = start;
        if (start) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next   = CAPTURE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The SIPO must not move while reset is held, even though state is already IDLE.
  assign sipo_shift_en = shift_en & ~rst;
  assign sipo_clr      = clr & ~rst;
  assign busy          = (state != IDLE);

  assign capture = (state == CAPTURE);
  assign accept  = word_valid & word_ready;
  assign load    = capture & (~word_valid | word_ready);
  assign drop    = capture & word_valid & ~word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      word_cnt   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        word_out   <= sipo_q;
        word_valid <= 1'b1;
        word_cnt   <= word_cnt + CNT_W'(1);
      end else if (accept) begin
        word_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: a SIPO stand-in feeds the DUT, and a frame-level
// model predicts every output on every cycle.
module tb_sipo_rx_ctrl;

  localparam int W = 4;
  localparam int CW = 8;

  logic          clk, rst;
  logic          start, abort, bit_valid, serial_in, word_ready, overrun_clr;
  logic          sipo_shift_en, sipo_clr, word_valid, busy, overrun;
  logic [W-1:0]  sipo_q, word_out;
  logic [CW-1:0] word_cnt;

  sipo_rx_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .sipo_shift_en(sipo_shift_en), .sipo_clr(sipo_clr), .sipo_q(sipo_q),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register the controller drives; new bits enter at the LSB.
  initial sipo_q = '0;
  always @(posedge clk) begin
    if (sipo_clr) sipo_q <= '0;
    else if (sipo_shift_en) sipo_q <= {sipo_q[W-2:0], serial_in};
  end

  int shift_pulses = 0;
  int clr_pulses = 0;
  always @(negedge clk) begin
    if (sipo_shift_en) shift_pulses++;
    if (sipo_clr) clr_pulses++;
  end

  // Frame-level model: a frame opens on start while idle, collects W accepted
  // bits MSB-first, and the following cycle hands the word to the output slot.
  bit in_frame, cap, m_valid, m_ovr;
  int nbits, frame_word, m_word, m_cnt;

  always @(posedge clk or posedge rst) begin : model
    bit ovr_set;
    if (rst) begin
      in_frame = 0; cap = 0; nbits = 0; frame_word = 0;
      m_word = 0; m_valid = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      ovr_set = 0;
      if (cap) begin
        if (!m_valid || word_ready) begin
          m_word = frame_word; m_valid = 1; m_cnt = (m_cnt + 1) % 256;
        end else ovr_set = 1;
      end else if (m_valid && word_ready) m_valid = 0;
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (cap) cap = 0;
      else if (!in_frame) begin
        if (start) begin in_frame = 1; nbits = 0; frame_word = 0; end
      end else if (abort) in_frame = 0;
      else if (bit_valid) begin
        frame_word = ((frame_word << 1) | int'(serial_in)) & ((1 << W) - 1);
        nbits++;
        if (nbits == W) begin in_frame = 0; cap = 1; end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sipo_shift_en", int'(sipo_shift_en), int'(!rst && in_frame && bit_valid && !abort));
    chk("sipo_clr", int'(sipo_clr), int'(!rst && !in_frame && !cap && start));
    chk("busy", int'(busy), int'(in_frame || cap));
    chk("word_valid", int'(word_valid), int'(m_valid));
    chk("word_out", int'(word_out), m_word);
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("word_cnt", int'(word_cnt), m_cnt);
  endtask

  // Apply inputs for one cycle, compare mid-cycle, then step past the edge.
  task automatic cyc(input logic st, input logic bv, input logic si, input logic ab,
                     input logic rdy, input logic oc);
    start = st; bit_valid = bv; serial_in = si; abort = ab; word_ready = rdy; overrun_clr = oc;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] w, input logic cap_ready, input logic cap_oclr);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) cyc(0, 1, w[i], 0, 0, 0);
    cyc(0, 0, 0, 0, cap_ready, cap_oclr);
  endtask

  initial begin
    int p0, c0;
    rst = 1'b1;
    start = 0; abort = 0; bit_valid = 0; serial_in = 0; word_ready = 0; overrun_clr = 0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_word_cnt", int'(word_cnt), 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic frame, consumer not ready.
    frame(4'b1011, 0, 0);
    chk("t1_word_out", int'(word_out), 4'b1011);
    chk("t1_word_valid", int'(word_valid), 1);
    chk("t1_word_cnt", int'(word_cnt), 1);

    // Held word causes overrun; clear collides with a new overrun.
    frame(4'b0110, 0, 0);
    chk("t3_overrun", int'(overrun), 1);
    chk("t3_word_out", int'(word_out), 4'b1011);
    chk("t3_word_cnt", int'(word_cnt), 1);
    frame(4'b0101, 0, 1);
    chk("t3_set_wins", int'(overrun), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_cleared", int'(overrun), 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Accept in the capture cycle: new word loads, no overrun.
    frame(4'b1011, 0, 0);
    frame(4'b0110, 1, 0);
    chk("t4_word_valid", int'(word_valid), 1);
    chk("t4_word_out", int'(word_out), 4'b0110);
    chk("t4_overrun", int'(overrun), 0);
    chk("t4_word_cnt", int'(word_cnt), 3);
    cyc(0, 0, 0, 0, 1, 0);

    // Stalled bit stream.
    p0 = shift_pulses;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t2_not_yet", int'(word_out), 4'b0110);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_word_out", int'(word_out), 4'b1101);
    chk("t2_shift_pulses", shift_pulses - p0, 4);
    cyc(0, 0, 0, 0, 1, 0);

    // Abort after two bits, then a clean frame.
    c0 = clr_pulses;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    frame(4'b0011, 0, 0);
    chk("t5_word_out", int'(word_out), 4'b0011);
    chk("t5_clr_pulses", clr_pulses - c0, 2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);

    // Asynchronous reset mid-frame.
    cyc(0, 0, 0, 0, 1, 0);
    frame(4'b1001, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    start = 0; bit_valid = 0; word_ready = 0; abort = 0; overrun_clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_word_valid", int'(word_valid), 0);
    chk("t6_word_cnt", int'(word_cnt), 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) frame(4'($urandom), 1, 0);
    chk("t6_cnt_wrap", int'(word_cnt), 44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Sequencer for the team's serial-in/parallel-out shift register (`shift_sipo`-style datapath).
- Clears the SIPO, gates its shifting from a bit-valid strobe, and counts WIDTH accepted bits.
- Captures the assembled `parallel_out` word into a holding register and presents it on a valid/ready handshake.
- Sits between a serial bit source and a word-wide consumer.

Parameters:
- WIDTH, 4, word length in bits; must match the SIPO width; legal range 2..16.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin capture of one word; honoured only in IDLE.
- abort  input  1  abandon the word in progress; return to IDLE.
- bit_valid  input  1  serial_in carries a valid bit this cycle.
- sipo_shift_en  output  1  shift-enable to the SIPO; combinational.
- sipo_clr  output  1  synchronous clear to the SIPO; combinational.
- sipo_q  input  WIDTH  SIPO `parallel_out`.
- word_out  output  WIDTH  captured word, registered.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- busy  output  1  state != IDLE.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- word_cnt  output  CNT_W  count of words loaded into word_out; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, bit_cnt=0.
  - word_out=0, word_valid=0, overrun=0, word_cnt=0.
  - sipo_shift_en=0 and sipo_clr=0 while rst is high.
- FSM states IDLE, SHIFT, CAPTURE.
- IDLE:
  - sipo_clr = start.
  - start=1 -> SHIFT, bit_cnt<=0.
  - bit_valid is ignored; sipo_shift_en=0.
- SHIFT:
  - sipo_shift_en = bit_valid & ~abort.
  - On each accepted bit, bit_cnt<=bit_cnt+1.
  - Accepted bit with bit_cnt==WIDTH-1 -> CAPTURE, bit_cnt<=0.
  - bit_valid=0 stalls the count indefinitely; there is no timeout.
- CAPTURE (exactly one cycle):
  - sipo_q holds the complete word.
  - Loads word_out<=sipo_q, word_valid<=1, word_cnt<=word_cnt+1, then -> IDLE.
  - bit_valid is ignored.
- Latency:
  - The start cycle accepts no bit.
  - Last bit accepted in cycle k -> CAPTURE in cycle k+1 -> word_valid=1 from cycle k+2.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Handshake:
  - word_valid & word_ready at an edge -> word_valid<=0.
  - word_out is stable while word_valid=1 and word_ready=0.
- Simultaneous CAPTURE load and consumer accept (word_valid & word_ready) -> the new word loads, word_valid stays 1, no overrun.
- Overrun:
  - CAPTURE with word_valid=1 and word_ready=0 -> new word dropped.
  - word_out unchanged, word_cnt unchanged, overrun<=1.
- overrun_clr:
  - Clears overrun.
  - Same-cycle set and clear -> set wins.
- abort:
  - In SHIFT -> IDLE, bit_cnt<=0, no capture, no shift that cycle.
  - In IDLE or CAPTURE -> no effect; CAPTURE completes.
- start while busy=1 is ignored; it is not queued.
- The SIPO shifts new bits in at the LSB (left shift), so the first bit lands at word_out[WIDTH-1].
- Reset mid-operation returns everything to reset values immediately; the partial word is discarded.

Test Plan (all with WIDTH=4):
- Reset with rst=1 for 10 ns -> all outputs 0, busy=0; then start pulse, bits 1,0,1,1 on consecutive cycles, word_ready=0 -> word_valid=1 two cycles after the 4th bit, word_out=4'b1011, word_cnt=1.
- Bits 1,1,0,1 with bit_valid low for 3 cycles between the 2nd and 3rd bit -> sipo_shift_en pulses exactly 4 times, word_out=4'b1101 only after the 4th valid bit.
- Word 4'b1011 held with word_ready=0, second frame 0,1,1,0 completes -> overrun=1, word_out stays 4'b1011, word_cnt stays 1. Then overrun_clr together with a new completing frame -> overrun stays 1.
- word_ready=1 exactly in the CAPTURE cycle of the second frame 0,1,1,0 -> word_valid stays 1, word_out=4'b0110, overrun=0.
- abort after 2 bits, then a new start and frame 0,0,1,1 -> word_out=4'b0011; sipo_clr pulses on each start; the aborted bits never appear.
- rst asserted asynchronously mid-SHIFT (between clock edges) -> busy, word_valid and word_cnt read 0 before the next edge; 300 back-to-back frames -> word_cnt wraps to 44.
